// File: rtl/bus_pkg.sv
// Shared definitions for the bus transfer sequencer: bus source/destination
// codes, their counts, the sequencer FSM state type and a legality helper.
package bus_pkg;

   // Source codes (bit index into out_strobe)
   localparam int unsigned SRC_R0  = 0,  SRC_R1  = 1,  SRC_R2  = 2,  SRC_R3  = 3;
   localparam int unsigned SRC_R4  = 4,  SRC_R5  = 5,  SRC_R6  = 6,  SRC_R7  = 7;
   localparam int unsigned SRC_R8  = 8,  SRC_R9  = 9,  SRC_R10 = 10, SRC_R11 = 11;
   localparam int unsigned SRC_R12 = 12, SRC_R13 = 13, SRC_R14 = 14, SRC_R15 = 15;
   localparam int unsigned SRC_LO  = 16, SRC_HI  = 17, SRC_ZLOW = 18, SRC_ZHIGH = 19;
   localparam int unsigned SRC_PC  = 20, SRC_MDR = 21, SRC_INPORT = 22, SRC_C = 23;

   // Destination codes (bit index into in_strobe)
   localparam int unsigned DST_R0  = 0,  DST_R1  = 1,  DST_R2  = 2,  DST_R3  = 3;
   localparam int unsigned DST_R4  = 4,  DST_R5  = 5,  DST_R6  = 6,  DST_R7  = 7;
   localparam int unsigned DST_R8  = 8,  DST_R9  = 9,  DST_R10 = 10, DST_R11 = 11;
   localparam int unsigned DST_R12 = 12, DST_R13 = 13, DST_R14 = 14, DST_R15 = 15;
   localparam int unsigned DST_LO  = 16, DST_HI  = 17, DST_Y   = 18, DST_Z   = 19;
   localparam int unsigned DST_PC  = 20, DST_MDR = 21, DST_MAR = 22, DST_OUTPORT = 23;
   localparam int unsigned DST_IR  = 24;

   localparam int unsigned NUM_SRC = 24;
   localparam int unsigned NUM_DST = 25;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      LOAD  = 2'd2
   } seqState_e;

   // A request is legal when both codes name an existing driver/register
   function automatic logic isLegalReq(input int unsigned src, input int unsigned dst);
      return (src < NUM_SRC) && (dst < NUM_DST);
   endfunction

endpackage

// File: rtl/bus_req_fifo.sv
// Synchronous request FIFO (no bypass); pointers wrap modulo DEPTH and the
// count carries one extra bit so full and empty are distinct.
module bus_req_fifo #(
   parameter int unsigned WIDTH = 10,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             push,
   input  logic [WIDTH-1:0] wrData,
   input  logic             pop,
   output logic [WIDTH-1:0] rdData,
   output logic             full,
   output logic             empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wrPtr;
   logic [PTR_W-1:0] rdPtr;
   logic [CNT_W-1:0] count;
   logic             doPush;
   logic             doPop;

   assign doPush = push && !full;
   assign doPop  = pop && !empty;
   assign full   = (count == CNT_W'(DEPTH));
   assign empty  = (count == '0);
   assign rdData = mem[rdPtr];

   // Pointer and occupancy tracking
   always_ff @(posedge clk) begin
      if (!clr) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (doPush) wrPtr <= wrPtr + PTR_W'(1);
         if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
         case ({doPush, doPop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage; contents need no reset because the pointers gate visibility
   always_ff @(posedge clk) begin
      if (doPush) mem[wrPtr] <= wrData;
   end

endmodule

// File: rtl/bus_transfer_sequencer.sv
// Bus transfer sequencer: pops queued {src,dst} moves and, for each legal
// one, produces a DRIVE cycle (source out strobe) then a LOAD cycle (source
// plus destination in strobe, done pulse). Illegal requests pulse err.
// Optional macro BUS_SNOOP_EN captures bus_in on every LOAD into snoop_data.
module bus_transfer_sequencer
   import bus_pkg::*;
#(
   parameter int unsigned wordSize = 32,
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned SEL_W    = 5
) (
   input  logic                clk,
   input  logic                clr,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [SEL_W-1:0]    req_src,
   input  logic [SEL_W-1:0]    req_dst,
   output logic [NUM_SRC-1:0]  out_strobe,
   output logic [NUM_DST-1:0]  in_strobe,
   input  logic [wordSize-1:0] bus_in,
   output logic                busy,
   output logic                done,
   output logic                err,
   output logic [wordSize-1:0] snoop_data
);

   localparam int unsigned REQ_W = 2 * SEL_W;

   seqState_e          state;
   seqState_e          stateNext;
   logic [SEL_W-1:0]   curSrc;
   logic [SEL_W-1:0]   curDst;
   logic [SEL_W-1:0]   srcNext;
   logic [SEL_W-1:0]   dstNext;
   logic [REQ_W-1:0]   headReq;
   logic [SEL_W-1:0]   headSrc;
   logic [SEL_W-1:0]   headDst;
   logic               headLegal;
   logic               fifoFull;
   logic               fifoEmpty;
   logic               push;
   logic               pop;
   logic [NUM_SRC-1:0] outNext;
   logic [NUM_DST-1:0] inNext;
   logic               doneNext;
   logic               errNext;

   assign push      = req_valid && req_ready;
   assign req_ready = !fifoFull;
   assign busy      = (state != IDLE) || !fifoEmpty;
   assign headSrc   = headReq[REQ_W-1:SEL_W];
   assign headDst   = headReq[SEL_W-1:0];
   assign headLegal = isLegalReq(32'(headSrc), 32'(headDst));

   bus_req_fifo #(
      .WIDTH (REQ_W),
      .DEPTH (DEPTH)
   ) reqFifo (
      .clk    (clk),
      .clr    (clr),
      .push   (push),
      .wrData ({req_src, req_dst}),
      .pop    (pop),
      .rdData (headReq),
      .full   (fifoFull),
      .empty  (fifoEmpty)
   );

   // Next state, pop decision and next strobe values
   always_comb begin
      stateNext = state;
      srcNext   = curSrc;
      dstNext   = curDst;
      pop       = 1'b0;
      outNext   = '0;
      inNext    = '0;
      doneNext  = 1'b0;
      errNext   = 1'b0;
      case (state)
         IDLE, LOAD: begin
            stateNext = IDLE;
            if (!fifoEmpty) begin
               pop = 1'b1;
               if (headLegal) begin
                  stateNext = DRIVE;
                  srcNext   = headSrc;
                  dstNext   = headDst;
                  outNext   = NUM_SRC'(1) << headSrc;
               end else begin
                  errNext = 1'b1;
               end
            end
         end
         DRIVE: begin
            stateNext = LOAD;
            outNext   = NUM_SRC'(1) << curSrc;
            inNext    = NUM_DST'(1) << curDst;
            doneNext  = 1'b1;
         end
         default: stateNext = IDLE;
      endcase
   end

   // State and registered strobe outputs
   always_ff @(posedge clk) begin
      if (!clr) begin
         state      <= IDLE;
         curSrc     <= '0;
         curDst     <= '0;
         out_strobe <= '0;
         in_strobe  <= '0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         state      <= stateNext;
         curSrc     <= srcNext;
         curDst     <= dstNext;
         out_strobe <= outNext;
         in_strobe  <= inNext;
         done       <= doneNext;
         err        <= errNext;
      end
   end

`ifdef BUS_SNOOP_EN
   // Capture the bus on the edge that ends LOAD, alongside the destination
   always_ff @(posedge clk) begin
      if (!clr) begin
         snoop_data <= '0;
      end else if (state == LOAD) begin
         snoop_data <= bus_in;
      end
   end
`else
   logic unusedBusIn;
   assign unusedBusIn = ^bus_in;
   assign snoop_data  = '0;
`endif

endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// Bench for bus_transfer_sequencer: directed scenarios plus random traffic,
// checked every cycle against a schedule model that assigns each accepted
// request its pop edge and derives the strobe/done/err timeline from it.
module tb_bus_transfer_sequencer;

   localparam int unsigned W     = 32;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned SEL_W = 5;
   localparam int          MAXC  = 4096;

   logic             clk;
   logic             clr;
   logic             req_valid;
   logic             req_ready;
   logic [SEL_W-1:0] req_src;
   logic [SEL_W-1:0] req_dst;
   logic [23:0]      out_strobe;
   logic [24:0]      in_strobe;
   logic [W-1:0]     bus_in;
   logic             busy;
   logic             done;
   logic             err;
   logic [W-1:0]     snoop_data;

   bus_transfer_sequencer #(
      .wordSize (W),
      .DEPTH    (DEPTH),
      .SEL_W    (SEL_W)
   ) dut (
      .clk        (clk),
      .clr        (clr),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_src    (req_src),
      .req_dst    (req_dst),
      .out_strobe (out_strobe),
      .in_strobe  (in_strobe),
      .bus_in     (bus_in),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .snoop_data (snoop_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int nChecks = 0;
   int nPass   = 0;

   // Expected outputs, indexed by cycle (cycle c = interval after edge c)
   logic [23:0] expOut  [MAXC];
   logic [24:0] expIn   [MAXC];
   logic        expDone [MAXC];
   logic        expErr  [MAXC];
   logic [W-1:0] expSnoop;
   int recN[$];   // push edge of each live request
   int recP[$];   // pop edge of each live request
   int freeEdge;  // earliest edge at which the sequencer can pop again
   int cyc;

   task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nChecks++;
      if (obs === exp) nPass++;
      else $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", tag, cyc, obs, exp);
   endtask

   function automatic int modelCount(input int c);
      int n = 0;
      foreach (recN[i]) if (recN[i] <= c && recP[i] > c) n++;
      return n;
   endfunction

   task automatic modelReset(input int r);
      for (int i = r; i < MAXC; i++) begin
         expOut[i] = '0; expIn[i] = '0; expDone[i] = 1'b0; expErr[i] = 1'b0;
      end
      recN.delete();
      recP.delete();
      freeEdge = r + 1;
   endtask

   task automatic modelPush(input int n, input int s, input int d);
      int p;
      p = (n + 1 > freeEdge) ? n + 1 : freeEdge;
      recN.push_back(n);
      recP.push_back(p);
      if (s <= 23 && d <= 24) begin
         expOut[p]    = 24'(1) << s;
         expOut[p+1]  = 24'(1) << s;
         expIn[p+1]   = 25'(1) << d;
         expDone[p+1] = 1'b1;
         freeEdge     = p + 2;
      end else begin
         expErr[p] = 1'b1;
         freeEdge  = p + 1;
      end
   endtask

   task automatic checkCycle();
      int cnt;
      cnt = modelCount(cyc);
      checkEq("out_strobe", 64'(out_strobe), 64'(expOut[cyc]));
      checkEq("in_strobe",  64'(in_strobe),  64'(expIn[cyc]));
      checkEq("done",       64'(done),       64'(expDone[cyc]));
      checkEq("err",        64'(err),        64'(expErr[cyc]));
      checkEq("req_ready",  64'(req_ready),  64'(cnt < DEPTH));
      checkEq("busy",       64'(busy),       64'((expOut[cyc] != '0) || (cnt != 0)));
      checkEq("snoop_data", 64'(snoop_data), 64'(expSnoop));
   endtask

   // One clock: check current cycle, drive inputs for the next edge, advance
   task automatic step(input logic rstN, input logic v, input logic [4:0] s,
                       input logic [4:0] d, input logic [W-1:0] b);
      logic [W-1:0] snoopNext;
      checkCycle();
      clr = rstN; req_valid = v; req_src = s; req_dst = d; bus_in = b;
      snoopNext = expSnoop;
`ifdef BUS_SNOOP_EN
      if (expDone[cyc]) snoopNext = b;
`endif
      if (!rstN) begin
         modelReset(cyc + 1);
         snoopNext = '0;
      end else if (v && modelCount(cyc) < DEPTH) begin
         modelPush(cyc + 1, int'(s), int'(d));
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
      expSnoop = snoopNext;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 5'd0, 5'd0, $urandom());
   endtask

   initial begin
      clr = 1'b0; req_valid = 1'b0; req_src = '0; req_dst = '0; bus_in = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      cyc = 0;
      expSnoop = '0;
      modelReset(0);
      step(1'b0, 1'b0, 5'd0, 5'd0, '0);

      // Single transfer R3 -> R7
      step(1'b1, 1'b1, 5'd3, 5'd7, $urandom());
      checkEq("single_idle_out", 64'(out_strobe), 64'h0);
      idle(1);
      checkEq("single_drive_out", 64'(out_strobe), 64'h000008);
      checkEq("single_drive_in",  64'(in_strobe),  64'h0);
      idle(1);
      checkEq("single_load_out",  64'(out_strobe), 64'h000008);
      checkEq("single_load_in",   64'(in_strobe),  64'h0000080);
      checkEq("single_load_done", 64'(done),       64'h1);
      idle(1);
      checkEq("single_after_out", 64'(out_strobe), 64'h0);
      checkEq("single_after_busy", 64'(busy),      64'h0);
      idle(2);

      // Back-to-back moves
      step(1'b1, 1'b1, 5'd20, 5'd22, $urandom());
      step(1'b1, 1'b1, 5'd21, 5'd24, $urandom());
      checkEq("b2b_first_drive", 64'(out_strobe), 64'(24'(1) << 20));
      step(1'b1, 1'b1, 5'd16, 5'd0,  $urandom());
      checkEq("b2b_first_load_in", 64'(in_strobe), 64'(25'(1) << 22));
      step(1'b1, 1'b1, 5'd23, 5'd19, $urandom());
      idle(10);

      // Illegal source followed by a legal move
      step(1'b1, 1'b1, 5'd25, 5'd3, $urandom());
      step(1'b1, 1'b1, 5'd1,  5'd2, $urandom());
      checkEq("illegal_err",  64'(err),        64'h1);
      checkEq("illegal_none", 64'(out_strobe), 64'h0);
      idle(6);

      // Reset during the first DRIVE with further requests queued
      step(1'b1, 1'b1, 5'd4, 5'd5, $urandom());
      step(1'b1, 1'b1, 5'd6, 5'd7, $urandom());
      step(1'b0, 1'b1, 5'd8, 5'd9, $urandom());
      checkEq("rst_out",   64'(out_strobe), 64'h0);
      checkEq("rst_busy",  64'(busy),       64'h0);
      checkEq("rst_ready", 64'(req_ready),  64'h1);
      for (int i = 0; i < 6; i++) begin
         step(1'b1, 1'b0, 5'd0, 5'd0, $urandom());
         checkEq("rst_no_done", 64'(done), 64'h0);
      end

      // Full boundary: hold valid across a fill and subsequent pops
      for (int i = 0; i < 12; i++)
         step(1'b1, 1'b1, 5'($urandom_range(0, 23)), 5'($urandom_range(0, 24)), $urandom());
      idle(12);

      // Snoop capture on LOAD of MDR -> R5
      step(1'b1, 1'b1, 5'd21, 5'd5, 32'hDEADBEEF);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 5'd0, 5'd0, 32'hDEADBEEF);
`ifdef BUS_SNOOP_EN
      checkEq("snoop_value", 64'(snoop_data), 64'hDEADBEEF);
`else
      checkEq("snoop_value", 64'(snoop_data), 64'h0);
`endif
      idle(2);

      // Random traffic with varying load, illegal codes and occasional reset
      for (int i = 0; i < 800; i++) begin
         logic [4:0] s;
         logic [4:0] d;
         logic       v;
         logic       rn;
         v  = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 85 : 35));
         s  = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(24, 31)) : 5'($urandom_range(0, 23));
         d  = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(25, 31)) : 5'($urandom_range(0, 24));
         rn = ($urandom_range(0, 99) != 0);
         step(rn, v, s, d, $urandom());
      end
      idle(10);

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
